// File: rtl/scan_sequencer.sv
// scan_sequencer: round-robin channel scanner for a downstream 4:1 mux.
// Each enabled channel is selected for DWELL cycles; disabled channels are
// skipped. Optional blanking between channels is compiled in when the macro
// SCAN_BLANK_EN is defined (BLANK cycles with all strobes low after each
// channel change); without it BLANK is only range-checked.
module scan_sequencer #(
    parameter int unsigned DWELL = 50000,
    parameter int unsigned BLANK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] en,
    input  logic       freeze,
    output logic [1:0] sel,
    output logic [3:0] strobe,
    output logic       advance
);

    localparam int unsigned   DW         = $clog2(DWELL);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

`ifdef SCAN_BLANK_EN
    localparam int unsigned   BW         = 8;
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DWELL    = 2'd1,
        S_BLANKING = 2'd2
    } state_t;
`else
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DWELL = 1'b1
    } state_t;
`endif

    // Reject out-of-range configurations at elaboration time.
    if (DWELL < 2 || DWELL > (1 << 24) || BLANK < 1 || BLANK > 255) begin : g_bad_params
        $error("scan_sequencer: DWELL or BLANK parameter out of range");
    end

    state_t        r_state;
    logic [1:0]    r_sel;
    logic [DW-1:0] r_dwell_cnt;
    logic          r_advance;

    state_t        w_state_nxt;
    logic [1:0]    w_sel_nxt;
    logic [DW-1:0] w_dwell_cnt_nxt;
    logic          w_advance_nxt;

`ifdef SCAN_BLANK_EN
    logic [BW-1:0] r_blank_cnt;
    logic [BW-1:0] w_blank_cnt_nxt;
`endif

    logic [1:0]    w_first_ch;   // lowest enabled index at or after r_sel
    logic [1:0]    w_next_ch;    // first enabled index strictly after r_sel
    logic [3:0]    w_strobe;

    // Lowest enabled channel at or after 'start', wrapping 3 -> 0.
    // Returns 'start' when the mask is empty (caller never relies on it then).
    function automatic logic [1:0] f_first_from(input logic [1:0] start,
                                                input logic [3:0] mask);
        logic [1:0] res;
        logic [1:0] idx;
        res = start;
        // Walk offsets 3..0 so the smallest matching offset is written last.
        for (int unsigned k = 4; k > 0; k--) begin
            idx = start + 2'(k - 1);
            if (mask[idx]) begin
                res = idx;
            end
        end
        return res;
    endfunction

    // Channel search results used by the next-state logic.
    always_comb begin
        w_first_ch = f_first_from(r_sel, en);
        w_next_ch  = f_first_from(r_sel + 2'd1, en);
    end

    // Next-state, next-select, counter and advance-pulse logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_sel_nxt       = r_sel;
        w_dwell_cnt_nxt = r_dwell_cnt;
        w_advance_nxt   = 1'b0;
`ifdef SCAN_BLANK_EN
        w_blank_cnt_nxt = r_blank_cnt;
`endif

        if (en == '0) begin
            w_state_nxt     = S_IDLE;
            w_dwell_cnt_nxt = '0;
`ifdef SCAN_BLANK_EN
            w_blank_cnt_nxt = '0;
`endif
        end else if (freeze) begin
            // Hold everything; advance stays low.
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt     = S_DWELL;
                    w_sel_nxt       = w_first_ch;
                    w_advance_nxt   = (w_first_ch != r_sel);
                    w_dwell_cnt_nxt = '0;
                end

                S_DWELL: begin
                    if (!en[r_sel]) begin
                        // Current channel withdrawn mid-dwell: hop immediately.
                        w_sel_nxt       = w_next_ch;
                        w_advance_nxt   = 1'b1;
                        w_dwell_cnt_nxt = '0;
`ifdef SCAN_BLANK_EN
                        w_state_nxt     = S_BLANKING;
                        w_blank_cnt_nxt = '0;
`endif
                    end else if (r_dwell_cnt == DWELL_LAST) begin
                        w_dwell_cnt_nxt = '0;
                        // A lone enabled channel simply restarts its dwell.
                        if (w_next_ch != r_sel) begin
                            w_sel_nxt     = w_next_ch;
                            w_advance_nxt = 1'b1;
`ifdef SCAN_BLANK_EN
                            w_state_nxt     = S_BLANKING;
                            w_blank_cnt_nxt = '0;
`endif
                        end
                    end else begin
                        w_dwell_cnt_nxt = r_dwell_cnt + DW'(1);
                    end
                end

`ifdef SCAN_BLANK_EN
                S_BLANKING: begin
                    if (!en[r_sel]) begin
                        // Target withdrawn during blanking: re-target and restart.
                        w_sel_nxt       = w_next_ch;
                        w_advance_nxt   = 1'b1;
                        w_blank_cnt_nxt = '0;
                    end else if (r_blank_cnt == BLANK_LAST) begin
                        w_state_nxt     = S_DWELL;
                        w_blank_cnt_nxt = '0;
                        w_dwell_cnt_nxt = '0;
                    end else begin
                        w_blank_cnt_nxt = r_blank_cnt + BW'(1);
                    end
                end
`endif

                default: begin
                    w_state_nxt     = S_IDLE;
                    w_dwell_cnt_nxt = '0;
                end
            endcase
        end
    end

    // State and counter registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sel       <= '0;
            r_dwell_cnt <= '0;
            r_advance   <= 1'b0;
`ifdef SCAN_BLANK_EN
            r_blank_cnt <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_dwell_cnt <= w_dwell_cnt_nxt;
            r_advance   <= w_advance_nxt;
`ifdef SCAN_BLANK_EN
            r_blank_cnt <= w_blank_cnt_nxt;
`endif
        end
    end

    // Strobe follows the live enable so a withdrawn channel drops instantly.
    always_comb begin
        w_strobe = '0;
        if (r_state == S_DWELL) begin
            w_strobe[r_sel] = en[r_sel];
        end
    end

    assign sel     = r_sel;
    assign strobe  = w_strobe;
    assign advance = r_advance;

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter DWELL, default 50000: clock cycles each channel stays selected; legal range 2..2^24.
REQ-002 Parameter BLANK, default 16: blanking cycles between channels; legal range 1..255; used only with SCAN_BLANK_EN.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port en  input  4  channel enable mask; bit i enables channel i.
REQ-006 Port freeze  input  1  holds the current channel and counters while high.
REQ-007 Port sel  output  2  registered channel index; drives the select input of the downstream 4:1 mux.
REQ-008 Port strobe  output  4  one-hot, active-high enable of the channel currently driven.
REQ-009 Port advance  output  1  registered one-cycle pulse marking the cycle sel takes a new value.

Function
REQ-010 States SHALL be IDLE, DWELL and, only with SCAN_BLANK_EN, BLANKING.
REQ-011 IDLE: en==0; sel holds, dwell counter held at 0, strobe=0; leave to DWELL on the first cycle en!=0.
REQ-012 On leaving IDLE, sel SHALL load the lowest enabled index at or after the current sel, modulo 4; advance pulses only if sel changes.
REQ-013 DWELL: dwell counter increments 0..DWELL-1 each cycle freeze==0.
REQ-014 At count DWELL-1, next sel = first enabled index after sel in order 0,1,2,3,0, skipping disabled channels; counter returns to 0.
REQ-015 If sel is the only enabled channel at terminal count, sel is unchanged, advance stays 0, and the counter restarts.
REQ-016 If en[sel] drops mid-dwell while en!=0, sel SHALL move to the next enabled channel on the following edge; counter resets; advance pulses.
REQ-017 If en becomes 0 in any state, the block SHALL enter IDLE on the next edge.
REQ-018 strobe[i] = (sel==i) & en[i] & (state==DWELL); combinational from registered state and en, so strobe=0 within the same cycle en[sel] drops.
REQ-019 freeze==1 SHALL hold the dwell counter, blank counter, state and sel; advance=0; strobe still follows REQ-018.
REQ-020 freeze has priority over terminal count and over REQ-016.
REQ-021 Priority: reset > en==0 > freeze > REQ-016 > terminal count.
REQ-022 Dwell counter width SHALL be ceil(log2(DWELL)); wrap only via REQ-014; no overflow.

Reset
REQ-023 While reset is high on a clock edge: sel=2'b00, state=IDLE, dwell and blank counters 0, advance=0.
REQ-024 The first edge after reset deasserts SHALL evaluate en per REQ-011/012.
REQ-025 Reset asserted mid-dwell or mid-blank SHALL abort the operation with no residual advance pulse.

Configuration
REQ-026 Macro SCAN_BLANK_EN, when defined, SHALL enable state BLANKING.
REQ-027 With SCAN_BLANK_EN: each sel change from DWELL (REQ-014, REQ-016) enters BLANKING for BLANK cycles with strobe=0, sel already at the new value, then DWELL with counter 0.
REQ-028 With SCAN_BLANK_EN: a drop of en[new sel] during BLANKING re-targets sel per REQ-016 and restarts BLANKING.
REQ-029 Without SCAN_BLANK_EN: no BLANKING state or blank counter; sel changes go straight to DWELL; BLANK is ignored.

Verification
REQ-030 With DWELL=4, macro off, en=4'b1111, reset released: sel steps 0,1,2,3,0 every 4 cycles; strobe 0001,0010,0100,1000; advance high once per step.
REQ-031 With DWELL=4, en=4'b1010: sel alternates 1,3,1; strobe never 0001 or 0100.
REQ-032 With DWELL=4, freeze=1 for 10 cycles mid-dwell on channel 2: sel stays 2, advance=0; after release, remaining dwell cycles complete before the move to 3.
REQ-033 With DWELL=4, sel=1, en changes from 1111 to 1101: strobe=0 in the same cycle; the next edge gives sel=2 with an advance pulse.
REQ-034 With DWELL=4, BLANK=2, macro on, en=1111: per channel, 2 cycles with strobe=0000 then 4 cycles with strobe one-hot; the advance pulse aligns with the first blank cycle.
REQ-035 With en=0000 after running: IDLE on the next edge, strobe=0000, sel held; reset asserted mid-dwell gives sel=0 and advance=0 on the next edge.
